// File: rtl/dac_attenuation_writer_if.sv
// Write-side bus for the attenuation DAC writer: register update strobe plus
// status flags returned to the fabric master.
interface dac_attenuation_writer_if;
  logic       wr;
  logic [1:0] wr_idx;
  logic [7:0] wr_value;
  logic       busy;
  logic [3:0] pending;

  modport master (
    output wr, wr_idx, wr_value,
    input  busy, pending
  );

  modport slave (
    input  wr, wr_idx, wr_value,
    output busy, pending
  );
endinterface

// File: rtl/dac_attenuation_writer.sv
// Dual AD7528 attenuation link transmitter: four shadow registers, each changed
// value serialised as a 9-bit {chan, value} frame under its DAC's chip select.
module dac_attenuation_writer #(
  parameter int unsigned CLK_DIV = 15
) (
  input  logic                     clk30,
  input  logic                     reset_n,
  dac_attenuation_writer_if.slave  bus,
  output logic                     datadac,
  output logic                     clkdac,
  output logic                     csdac1n,
  output logic                     csdac2n
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HI, S_LO, S_HOLD, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    shreg_q, shreg_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [1:0]    rr_q, rr_d;
  logic [3:0]    pend_q, pend_d;
  logic          clk_q, clk_d;
  logic          cs1_q, cs1_d;
  logic          cs2_q, cs2_d;
  logic          busy_q, busy_d;
  logic [7:0]    value_q [4];

  logic          phase_done;
  logic          found;
  logic [1:0]    pick;

  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 4; i++) value_q[i] <= '0;
    end else if (bus.wr) begin
      value_q[bus.wr_idx] <= bus.wr_value;
    end
  end

  always_ff @(posedge clk30 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      rr_q     <= 2'd3;
      pend_q   <= '1;
      clk_q    <= 1'b0;
      cs1_q    <= 1'b1;
      cs2_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      rr_q     <= rr_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      cs1_q    <= cs1_d;
      cs2_q    <= cs2_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    rr_d       = rr_q;
    pend_d     = pend_q;
    clk_d      = clk_q;
    cs1_d      = cs1_q;
    cs2_d      = cs2_q;
    found      = 1'b0;
    pick       = '0;
    phase_done = (cnt_q == CW'(CLK_DIV - 1));

    // Round-robin search starting just after the last index served.
    for (int unsigned k = 1; k <= 4; k++) begin
      if (!found && pend_q[rr_q + 2'(k)]) begin
        found = 1'b1;
        pick  = rr_q + 2'(k);
      end
    end

    if (state_q != S_IDLE) cnt_d = phase_done ? '0 : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          shreg_d      = {pick[0], value_q[pick]};
          pend_d[pick] = 1'b0;
          rr_d         = pick;
          bitcnt_d     = '0;
          cs1_d        = pick[1];
          cs2_d        = ~pick[1];
          state_d      = S_SETUP;
        end
      end
      S_SETUP: begin
        if (phase_done) begin
          clk_d   = 1'b1;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (phase_done) begin
          clk_d = 1'b0;
          if (bitcnt_q == 4'd8) begin
            state_d = S_HOLD;
          end else begin
            shreg_d  = {shreg_q[7:0], 1'b0};
            bitcnt_d = bitcnt_q + 4'd1;
            state_d  = S_LO;
          end
        end
      end
      S_LO: begin
        if (phase_done) begin
          clk_d   = 1'b1;
          state_d = S_HI;
        end
      end
      S_HOLD: begin
        if (phase_done) begin
          cs1_d   = 1'b1;
          cs2_d   = 1'b1;
          shreg_d = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (phase_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A write landing on the cycle its index is picked still leaves it pending.
    if (bus.wr) pend_d[bus.wr_idx] = 1'b1;

    busy_d = (state_d != S_IDLE);
  end

  assign datadac     = shreg_q[8];
  assign clkdac      = clk_q;
  assign csdac1n     = cs1_q;
  assign csdac2n     = cs2_q;
  assign bus.busy    = busy_q;
  assign bus.pending = pend_q;

endmodule

// File: tb/tb_dac_attenuation_writer.sv
// Scoreboard bench for dac_attenuation_writer: expected frames are queued as
// writes are issued and matched against frames decoded from the DAC pins.
module tb_dac_attenuation_writer;
  localparam int unsigned CLK_DIV = 15;
  localparam int LOW_CYCLES = 19 * CLK_DIV;

  logic clk30 = 1'b0;
  logic reset_n = 1'b0;
  logic datadac, clkdac, csdac1n, csdac2n;

  dac_attenuation_writer_if bus();

  dac_attenuation_writer #(.CLK_DIV(CLK_DIV)) dut (
    .clk30   (clk30),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .datadac (datadac),
    .clkdac  (clkdac),
    .csdac1n (csdac1n),
    .csdac2n (csdac2n)
  );

  always #5 clk30 = ~clk30;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];

  // Frame monitor: {dac select, chan bit, value}
  logic       in_frame = 1'b0;
  logic       which;
  logic [8:0] bits;
  int         rises, low_cycles;
  logic       both_low;
  logic       prev_clk = 1'b0;
  logic [9:0] got, want;

  always @(negedge clk30) begin
    if (!reset_n) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && (!csdac1n || !csdac2n)) begin
        in_frame   = 1'b1;
        which      = csdac1n;
        bits       = '0;
        rises      = 0;
        low_cycles = 0;
        both_low   = 1'b0;
      end
      if (in_frame) begin
        if (!csdac1n && !csdac2n) both_low = 1'b1;
        if (csdac1n && csdac2n) begin
          in_frame = 1'b0;
          got = {which, bits};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected: got %h, required none", got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              errors++;
              $display("FAIL frame_data: got %h, required %h", got, want);
            end
          end
          checks++;
          if (rises !== 9) begin
            errors++;
            $display("FAIL frame_edges: got %0d, required 9", rises);
          end
          checks++;
          if (low_cycles !== LOW_CYCLES) begin
            errors++;
            $display("FAIL cs_low_len: got %0d, required %0d", low_cycles, LOW_CYCLES);
          end
          checks++;
          if (both_low !== 1'b0) begin
            errors++;
            $display("FAIL cs_exclusive: got both low, required one low");
          end
        end else begin
          low_cycles++;
          if (clkdac && !prev_clk) begin
            bits = {bits[7:0], datadac};
            rises++;
          end
        end
      end
    end
    prev_clk = clkdac;
  end

  function automatic logic [9:0] frame_of(input logic [1:0] idx, input logic [7:0] val);
    return {idx, val};
  endfunction

  task automatic wr_one(input logic [1:0] idx, input logic [7:0] val);
    @(negedge clk30);
    bus.wr       = 1'b1;
    bus.wr_idx   = idx;
    bus.wr_value = val;
    @(negedge clk30);
    bus.wr = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk30);
      n++;
    end while (!(bus.busy === 1'b0 && bus.pending === 4'h0 && !in_frame) && n < 5000);
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL %s_timeout: got busy=%b pending=%h, required idle", name, bus.busy, bus.pending);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_missing: got %0d frames outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_rises(input int nr, input string name);
    int   n = 0;
    int   seen = 0;
    logic pc = clkdac;
    while (seen < nr && n < 5000) begin
      @(negedge clk30);
      n++;
      if (clkdac && !pc) seen++;
      pc = clkdac;
    end
    checks++;
    if (seen < nr) begin
      errors++;
      $display("FAIL %s_edge_timeout: got %0d rises, required %0d", name, seen, nr);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk30);
    checks++;
    if ({csdac1n, csdac2n, clkdac, datadac, bus.busy} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_pins: got cs1=%b cs2=%b clk=%b data=%b busy=%b, required 1 1 0 0 0",
               csdac1n, csdac2n, clkdac, datadac, bus.busy);
    end
    checks++;
    if (bus.pending !== 4'hF) begin
      errors++;
      $display("FAIL reset_pending: got %h, required f", bus.pending);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(frame_of(2'(i), 8'h00));
    reset_n = 1'b1;
    wait_idle("reset_flush");
  endtask

  task automatic test_single_write;
    exp_q.push_back(frame_of(2'd2, 8'hA5));
    wr_one(2'd2, 8'hA5);
    wait_idle("single");
  endtask

  task automatic test_write_in_flight;
    exp_q.push_back(frame_of(2'd1, 8'h10));
    exp_q.push_back(frame_of(2'd1, 8'h7F));
    wr_one(2'd1, 8'h10);
    wait_rises(4, "inflight");
    wr_one(2'd1, 8'h7F);
    wait_idle("inflight");
  endtask

  task automatic test_round_robin;
    exp_q.push_back(frame_of(2'd1, 8'h22));
    wr_one(2'd1, 8'h22);
    wait_rises(1, "rr");
    wr_one(2'd0, 8'h30);
    wr_one(2'd1, 8'h31);
    wr_one(2'd3, 8'h33);
    checks++;
    if (bus.pending !== 4'b1011) begin
      errors++;
      $display("FAIL rr_pending: got %b, required 1011", bus.pending);
    end
    exp_q.push_back(frame_of(2'd3, 8'h33));
    exp_q.push_back(frame_of(2'd0, 8'h30));
    exp_q.push_back(frame_of(2'd1, 8'h31));
    wait_idle("rr");
  endtask

  task automatic test_back_to_back;
    exp_q.push_back(frame_of(2'd3, 8'h44));
    wr_one(2'd3, 8'h44);
    wait_rises(1, "b2b");
    wr_one(2'd0, 8'h01);
    wr_one(2'd0, 8'h02);
    wr_one(2'd0, 8'h03);
    checks++;
    if (bus.pending !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_pending: got %b, required 0001", bus.pending);
    end
    exp_q.push_back(frame_of(2'd0, 8'h03));
    wait_idle("b2b");
  endtask

  task automatic test_reset_mid_frame;
    wr_one(2'd2, 8'h5A);
    wait_rises(5, "midrst");
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({csdac1n, csdac2n, clkdac, bus.busy} !== 4'b1100) begin
      errors++;
      $display("FAIL midrst_pins: got cs1=%b cs2=%b clk=%b busy=%b, required 1 1 0 0",
               csdac1n, csdac2n, clkdac, bus.busy);
    end
    checks++;
    if (bus.pending !== 4'hF) begin
      errors++;
      $display("FAIL midrst_pending: got %h, required f", bus.pending);
    end
    repeat (3) @(negedge clk30);
    for (int i = 0; i < 4; i++) exp_q.push_back(frame_of(2'(i), 8'h00));
    reset_n = 1'b1;
    wait_idle("midrst");
  endtask

  initial begin
    bus.wr       = 1'b0;
    bus.wr_idx   = '0;
    bus.wr_value = '0;
    test_reset();
    test_single_write();
    test_write_in_flight();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_attenuation_writer.md
Name: dac_attenuation_writer

Overview:
- Serial transmitter for the dual AD7528 audio attenuation DAC link (datadac / clkdac / csdac1n / csdac2n).
- Holds four 8-bit attenuation shadow registers and serialises each changed value as a 9-bit chip-selected frame.
- Used in place of the 68HC05 port-B bit-bang when attenuation is driven from fabric logic (HLE slave, test harness).
- Its pin outputs connect directly to the existing attenuation receiver inputs.

Parameters:
- CLK_DIV, 15, clk30 cycles per clkdac half-period (15 gives 1 MHz clkdac); must be >= 1.

Ports:
- clk30  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- wr  input  1  single-cycle strobe, updates one shadow register
- wr_idx  input  2  register select: bit1 = DAC (0 = csdac1n, 1 = csdac2n), bit0 = channel (0 = A, 1 = B)
- wr_value  input  8  attenuation value
- busy  output  1  frame in progress
- pending  output  4  per-index "needs sending" flags
- datadac  output  1  serial data, MSB first
- clkdac  output  1  serial clock; receiver samples on rising edge
- csdac1n  output  1  chip select DAC1, active low
- csdac2n  output  1  chip select DAC2, active low

Behaviour:
- Clocking and reset:
  - Single clock domain (clk30); reset_n is asynchronous and active-low.
  - All outputs are registered.
- Reset values:
  - clkdac=0, datadac=0, csdac1n=1, csdac2n=1, busy=0.
  - pending=4'hF, so all four values are pushed after reset.
  - Shadow values=8'h00, rr pointer=3, state=IDLE.
- Write path:
  - wr: value[wr_idx] <= wr_value and pending[wr_idx] <= 1 on the next edge.
  - Accepted in any state.
- Frame content (9 bits): {chan bit = idx[0], value[7:0]}, sent MSB first.
- State machine (half-period counter cnt counts CLK_DIV cycles):
  - IDLE: if pending != 0, pick the first set index in order rr+1, rr+2, rr+3, rr+4 (mod 4).
    - Load the 9-bit shift register from the shadow value and clear that pending bit.
    - Set rr to the chosen index.
    - Drive the selected cs low, datadac = bit8, go to SETUP.
  - SETUP: clkdac=0 for CLK_DIV cycles, then go to HI.
  - HI: clkdac=1 for CLK_DIV cycles.
    - If 9 bits have been clocked, go to HOLD.
    - Otherwise go to LO and present the next bit on datadac.
  - LO: clkdac=0 for CLK_DIV cycles, then go to HI.
  - HOLD: clkdac=0, cs still low, for CLK_DIV cycles.
    - On exit both cs go high and datadac=0; go to GAP.
  - GAP: CLK_DIV cycles with cs high, then go to IDLE.
- Frame timing:
  - cs low for 19*CLK_DIV cycles; GAP adds CLK_DIV.
  - Exactly 9 clkdac rising edges per frame.
  - Total 20*CLK_DIV cycles + 1 IDLE cycle between consecutive frames.
- busy = (state != IDLE).
- Only one cs is ever low at a time; the two cs are never low together.
- Boundary rules:
  - Write to the index currently being shifted: the frame in flight keeps its snapshot; pending is set again and the new value is sent in a later frame.
  - Write on the same cycle IDLE clears that pending bit: the set wins, and the snapshot takes the old value.
  - Several writes to one index before it is served: only the last value is sent, once.
  - reset_n asserted mid-frame: outputs go to reset values immediately (cs high, clkdac low) and the partial frame is abandoned. After release all four values (now 0x00) are resent.

Test Plan:
- Release reset_n with no writes:
  - Four frames, idx 0,1,2,3, all data 0x00.
  - csdac1n low for frames 0–1, csdac2n for frames 2–3; chan bits 0,1,0,1.
  - Each cs-low window is 285 cycles (CLK_DIV=15); busy low after the fourth GAP.
- Idle, wr idx=2 value=0xA5:
  - csdac2n falls.
  - Bits sampled on the 9 clkdac rising edges are 0,1,0,1,0,0,1,0,1.
  - csdac1n stays high throughout; pending returns to 0.
- During frame idx=1 (value 0x10), wr idx=1 value=0x7F at the 4th rising edge:
  - The current frame completes with 1,00010000.
  - The next frame sends 1,01111111.
- Round robin: after idx 1 is served, set pending 4'b1011 simultaneously → service order 3, 0, 1.
- Assert reset_n during the 5th HI phase:
  - The same cycle shows cs high, clkdac 0, pending 4'hF.
  - After release, four fresh frames idx 0–3 with 0x00.
- Three writes to idx 0 (0x01, 0x02, 0x03) while busy on idx 3:
  - Exactly one idx-0 frame follows, data 0x03.
